// File: rtl/mof_pkg.sv
// Shared types and constants for the memory operand fetch stage.
// Optional macro MEMFETCH_SPLIT_UNALIGNED_EN is consumed by memory_operand_fetch.
package mof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic TAG_SRC1   = 1'b0;
    localparam logic TAG_SRC2   = 1'b1;
    localparam int   BEAT_BYTES = 8;

endpackage

// File: rtl/mof_align_merge.sv
// Combinational byte-shift merge of two little-endian beats by a byte offset.
// With off = 0 the result is simply lo and hi is ignored.
module mof_align_merge
    import mof_pkg::*;
#(
    parameter int DATA_W = BEAT_BYTES * 8
) (
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic [2:0]        off,
    output logic [DATA_W-1:0] merged
);

    logic [6:0] lo_sh;
    logic [6:0] hi_sh;

    // off = 0 is kept separate so hi is never shifted by the full beat width.
    always_comb begin
        lo_sh  = {1'b0, off, 3'b000};
        hi_sh  = 7'(DATA_W) - lo_sh;
        merged = lo;
        if (off != 3'd0) begin
            merged = (lo >> lo_sh) | (hi << hi_sh);
        end
    end

endmodule

// File: rtl/memory_operand_fetch.sv
// Memory operand fetch: turns source addresses into serial cache reads and resolves operands.
// Build option MEMFETCH_SPLIT_UNALIGNED_EN: fetch misaligned operands as two beats instead of flagging them.
module memory_operand_fetch
    import mof_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = BEAT_BYTES * 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic              isMemSrc1In,
    input  logic              isMemSrc2In,
    input  logic [ADDR_W-1:0] memAddrSrc1In,
    input  logic [ADDR_W-1:0] memAddrSrc2In,
    input  logic [DATA_W-1:0] operand1ValIn,
    input  logic [DATA_W-1:0] operand2ValIn,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic [ADDR_W-1:0] memReqAddr,
    output logic              memReqTag,
    input  logic              memRespValid,
    input  logic              memRespTag,
    input  logic [DATA_W-1:0] memRespData,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] operand1ValOut,
    output logic [DATA_W-1:0] operand2ValOut,
    output logic              fetchErrOut,
    output state_t            fsm_state
);

    // Handshakes (in/out/memReq): a transfer occurs at a rising edge where valid and ready
    // are both high; the sender keeps valid and payload stable until then. memResp has no ready.

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    state_t             state_next;
    logic               cursor;
    logic [CNT_W-1:0]   wait_cnt;
    logic               mem1_q;
    logic               mem2_q;
    logic [ADDR_W-1:0]  addr1_q;
    logic [ADDR_W-1:0]  addr2_q;
    logic [DATA_W-1:0]  op1_q;
    logic [DATA_W-1:0]  op2_q;
    logic               err_q;

    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  base_addr;
    logic [ADDR_W-1:0]  req_addr;
    logic [2:0]         cur_off;
    logic               misaligned;
    logic               more_src;
    logic               resp_hit;
    logic               beat;
    logic               skip_src;
    logic               lo_first;
    logic [DATA_W-1:0]  merge_lo;
    logic [2:0]         merge_off;
    logic [DATA_W-1:0]  merged;

    logic               accept;
    logic               src_skip;
    logic               src_done;
    logic               timeout;
    logic               cnt_inc;

    assign cur_addr   = (cursor == TAG_SRC2) ? addr2_q : addr1_q;
    assign cur_off    = cur_addr[2:0];
    assign misaligned = (cur_off != 3'd0);
    assign base_addr  = {cur_addr[ADDR_W-1:3], 3'b000};
    assign req_addr   = base_addr + (beat ? ADDR_W'(BEAT_BYTES) : {ADDR_W{1'b0}});
    assign more_src   = (cursor == TAG_SRC1) && mem2_q;
    assign resp_hit   = memRespValid && (memRespTag == cursor);
    assign merge_off  = beat ? cur_off : 3'd0;

`ifdef MEMFETCH_SPLIT_UNALIGNED_EN
    logic [DATA_W-1:0] lo_q;

    assign skip_src = 1'b0;
    assign lo_first = misaligned && !beat;
    assign merge_lo = beat ? lo_q : memRespData;

    // The hi address wraps naturally through the ADDR_W-wide add.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat <= 1'b0;
            lo_q <= '0;
        end else if (state == ST_WAIT && resp_hit && lo_first) begin
            beat <= 1'b1;
            lo_q <= memRespData;
        end else if (accept || src_done) begin
            beat <= 1'b0;
        end
    end
`else
    assign beat     = 1'b0;
    assign skip_src = misaligned;
    assign lo_first = 1'b0;
    assign merge_lo = memRespData;
`endif

    mof_align_merge #(.DATA_W(DATA_W)) u_merge (
        .lo     (merge_lo),
        .hi     (memRespData),
        .off    (merge_off),
        .merged (merged)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        inReady     = 1'b0;
        memReqValid = 1'b0;
        outValid    = 1'b0;
        accept      = 1'b0;
        src_skip    = 1'b0;
        src_done    = 1'b0;
        timeout     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    accept     = 1'b1;
                    state_next = (isMemSrc1In || isMemSrc2In) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (skip_src) begin
                    src_skip   = 1'b1;
                    state_next = more_src ? ST_REQ : ST_DONE;
                end else begin
                    memReqValid = 1'b1;
                    if (memReqReady) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (resp_hit) begin
                    if (lo_first) begin
                        state_next = ST_REQ;
                    end else begin
                        src_done   = 1'b1;
                        state_next = more_src ? ST_REQ : ST_DONE;
                    end
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cursor   <= TAG_SRC1;
            wait_cnt <= '0;
            mem1_q   <= 1'b0;
            mem2_q   <= 1'b0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                mem1_q  <= isMemSrc1In;
                mem2_q  <= isMemSrc2In;
                addr1_q <= memAddrSrc1In;
                addr2_q <= memAddrSrc2In;
                op1_q   <= operand1ValIn;
                op2_q   <= operand2ValIn;
                err_q   <= 1'b0;
                cursor  <= isMemSrc1In ? TAG_SRC1 : TAG_SRC2;
            end
            // A skipped source resolves to zero; a fetched one takes the merged beat(s).
            if (src_skip || src_done) begin
                if (cursor == TAG_SRC1) begin
                    op1_q <= src_done ? merged : '0;
                end else begin
                    op2_q <= src_done ? merged : '0;
                end
                cursor <= TAG_SRC2;
            end
            if (src_skip || timeout) begin
                err_q <= 1'b1;
            end
            if (cnt_inc) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign memReqAddr     = memReqValid ? req_addr : '0;
    assign memReqTag      = memReqValid ? cursor : 1'b0;
    assign operand1ValOut = op1_q;
    assign operand2ValOut = op2_q;
    assign fetchErrOut    = err_q;
    assign fsm_state      = state;

endmodule

// File: tb/tb_memory_operand_fetch.sv
// Bench for memory_operand_fetch: directed steps plus randomized instructions against a byte-level memory model.
// Expectations follow MEMFETCH_SPLIT_UNALIGNED_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_memory_operand_fetch;
    import mof_pkg::*;

    localparam int ADDR_W      = 64;
    localparam int DATA_W      = 64;
    localparam int TIMEOUT_CYC = 255;
    localparam int MAX_CYC     = 2000;
`ifdef MEMFETCH_SPLIT_UNALIGNED_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic              isMemSrc1In = 1'b0;
    logic              isMemSrc2In = 1'b0;
    logic [ADDR_W-1:0] memAddrSrc1In = '0;
    logic [ADDR_W-1:0] memAddrSrc2In = '0;
    logic [DATA_W-1:0] operand1ValIn = '0;
    logic [DATA_W-1:0] operand2ValIn = '0;
    logic              memReqValid;
    logic              memReqReady = 1'b0;
    logic [ADDR_W-1:0] memReqAddr;
    logic              memReqTag;
    logic              memRespValid = 1'b0;
    logic              memRespTag = 1'b0;
    logic [DATA_W-1:0] memRespData = '0;
    logic              outValid;
    logic              outReady = 1'b0;
    logic [DATA_W-1:0] operand1ValOut;
    logic [DATA_W-1:0] operand2ValOut;
    logic              fetchErrOut;
    state_t            dbg_state;

    memory_operand_fetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
        .isMemSrc1In(isMemSrc1In), .isMemSrc2In(isMemSrc2In),
        .memAddrSrc1In(memAddrSrc1In), .memAddrSrc2In(memAddrSrc2In),
        .operand1ValIn(operand1ValIn), .operand2ValIn(operand2ValIn),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqAddr(memReqAddr), .memReqTag(memReqTag),
        .memRespValid(memRespValid), .memRespTag(memRespTag), .memRespData(memRespData),
        .outValid(outValid), .outReady(outReady),
        .operand1ValOut(operand1ValOut), .operand2ValOut(operand2ValOut),
        .fetchErrOut(fetchErrOut), .fsm_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; inValid = 1'b0; memReqReady = 1'b0; memRespValid = 1'b0; outReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W:0] exp_q[$];  // expected requests {tag, addr}
    logic [ADDR_W:0] got_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [7:0]  salt = 8'h00;
    bit          ovr_en = 1'b0;
    logic [63:0] ovr_val = '0;

    function automatic logic [7:0] byte_at(input logic [63:0] a);
        return a[7:0] ^ a[31:24] ^ a[63:56] ^ salt;
    endfunction

    function automatic logic [63:0] bytes_from(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = byte_at(a + 64'(i));
        return w;
    endfunction

    function automatic logic [63:0] word_at(input logic [63:0] a);
        return ovr_en ? ovr_val : bytes_from(a);
    endfunction

    // ---------------- driver / cache responder ----------------
    int          rd_cfg = 0, rsp_cfg = 0, hold_cfg = 0;
    bit          wrong_cfg = 1'b0, noresp_cfg = 1'b0;
    logic [63:0] got_op1, got_op2;
    logic        got_err;
    int          got_lat;
    bit          timed_out, inready_bad, hold_bad, req_hold_bad;

    task automatic run_instr(input bit m1, input bit m2, input logic [63:0] a1, input logic [63:0] a2,
                             input logic [63:0] v1, input logic [63:0] v2);
        bit              pend, wrong_left, stalling;
        logic            pend_tag;
        logic [63:0]     pend_data;
        int              pend_wait, stall_left;
        logic [ADDR_W:0] held;
        pend = 0; wrong_left = 0; stalling = 0; pend_tag = 0; pend_data = '0;
        pend_wait = 0; stall_left = 0; held = '0;
        got_q.delete();
        timed_out = 1; inready_bad = 0; hold_bad = 0; req_hold_bad = 0;
        got_op1 = '0; got_op2 = '0; got_err = 0; got_lat = 0;
        @(negedge clk);
        inValid = 1'b1; isMemSrc1In = m1; isMemSrc2In = m2;
        memAddrSrc1In = a1; memAddrSrc2In = a2; operand1ValIn = v1; operand2ValIn = v2;
        @(posedge clk);
        for (int i = 1; i <= MAX_CYC; i++) begin
            @(negedge clk);
            if (i == 1) begin
                inValid = 1'b0;
                isMemSrc1In = 1'($urandom); isMemSrc2In = 1'($urandom);
                memAddrSrc1In = {$urandom, $urandom}; memAddrSrc2In = {$urandom, $urandom};
                operand1ValIn = {$urandom, $urandom}; operand2ValIn = {$urandom, $urandom};
            end
            memReqReady = 1'b0; memRespValid = 1'b0; memRespTag = 1'b0; memRespData = '0;
            if (outValid) begin
                got_lat = i; got_op1 = operand1ValOut; got_op2 = operand2ValOut;
                got_err = fetchErrOut; timed_out = 0;
                for (int h = 0; h < hold_cfg; h++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (!outValid || operand1ValOut !== got_op1 || operand2ValOut !== got_op2 ||
                        fetchErrOut !== got_err) hold_bad = 1;
                end
                outReady = 1'b1;
                @(posedge clk);
                @(negedge clk);
                outReady = 1'b0;
                break;
            end
            if (inReady) inready_bad = 1;
            if (pend) begin
                if (pend_wait > 0) begin
                    pend_wait--;
                end else if (wrong_left) begin
                    memRespValid = 1'b1; memRespTag = ~pend_tag; memRespData = ~pend_data;
                    wrong_left = 0;
                end else begin
                    memRespValid = 1'b1; memRespTag = pend_tag; memRespData = pend_data;
                    pend = 0;
                end
            end
            if (memReqValid) begin
                if (stalling) begin
                    if ({memReqTag, memReqAddr} !== held) req_hold_bad = 1;
                end else begin
                    stalling = 1; stall_left = rd_cfg; held = {memReqTag, memReqAddr};
                end
                if (stall_left == 0) begin
                    memReqReady = 1'b1;
                    got_q.push_back({memReqTag, memReqAddr});
                    stalling = 0;
                    if (!noresp_cfg) begin
                        pend = 1; pend_tag = memReqTag; pend_data = word_at(memReqAddr);
                        pend_wait = rsp_cfg; wrong_left = wrong_cfg;
                    end
                end else begin
                    stall_left--;
                end
            end
            @(posedge clk);
        end
    endtask

    // Reference: expected operands, error flag, request list and zero-wait-adjusted latency.
    task automatic do_case(input string name, input bit m1, input bit m2, input logic [63:0] a1,
                           input logic [63:0] a2, input logic [63:0] v1, input logic [63:0] v2);
        logic [63:0] e1, e2, a, r, base;
        logic        ee, m;
        int          lat, per;
        e1 = v1; e2 = v2; ee = 0; lat = 1;
        per = 2 + rd_cfg + rsp_cfg + int'(wrong_cfg);
        exp_q.delete();
        for (int s = 0; s < 2; s++) begin
            m = (s == 0) ? m1 : m2;
            a = (s == 0) ? a1 : a2;
            if (!m) continue;
            base = a & ~64'd7;
            if (a[2:0] == 3'd0) begin
                exp_q.push_back({1'(s), a});
                r = word_at(a);
                lat += per;
            end else if (SPLIT) begin
                exp_q.push_back({1'(s), base});
                exp_q.push_back({1'(s), base + 64'd8});
                r = bytes_from(a);
                lat += 2 * per;
            end else begin
                r = '0; ee = 1; lat += 1;
            end
            if (s == 0) e1 = r; else e2 = r;
        end
        run_instr(m1, m2, a1, a2, v1, v2);
        check({name, ".timeout"}, 64'(timed_out), 64'd0);
        check({name, ".op1"}, got_op1, e1);
        check({name, ".op2"}, got_op2, e2);
        check({name, ".err"}, 64'(got_err), 64'(ee));
        check({name, ".latency"}, 64'(got_lat), 64'(lat));
        check({name, ".inready_busy"}, 64'(inready_bad), 64'd0);
        check({name, ".out_hold"}, 64'(hold_bad), 64'd0);
        check({name, ".req_hold"}, 64'(req_hold_bad), 64'd0);
        check({name, ".nreq"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s.req%0d", name, k), got_q[k][63:0] | 64'(got_q[k][64]) << 0 ^ 64'(0),
                  exp_q[k][63:0] | 64'(exp_q[k][64]) << 0 ^ 64'(0));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s.tag%0d", name, k), 64'(got_q[k][64]), 64'(exp_q[k][64]));
        if (timed_out) do_reset();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] a1, a2;
        do_reset();
        check("rst.inReady", 64'(inReady), 64'd1);
        check("rst.outValid", 64'(outValid), 64'd0);
        check("rst.memReqValid", 64'(memReqValid), 64'd0);
        check("rst.memReqAddr", memReqAddr, 64'd0);
        check("rst.op1", operand1ValOut, 64'd0);
        check("rst.op2", operand2ValOut, 64'd0);
        check("rst.err", 64'(fetchErrOut), 64'd0);

        do_case("nomem", 0, 0, 64'h8000, 64'h9000, 64'h11, 64'h22);

        ovr_en = 1; ovr_val = 64'hDEADBEEF_CAFEF00D;
        do_case("src1", 1, 0, 64'h1000, 64'h0, 64'h5555, 64'h7777);
        check("src1.op1_const", got_op1, 64'hDEADBEEFCAFEF00D);
        ovr_en = 0;

        salt = 8'h3C; rd_cfg = 3; hold_cfg = 2;
        do_case("both_stall", 1, 1, 64'h2000, 64'h3008, 64'h1, 64'h2);
        rd_cfg = 0; hold_cfg = 0;

        wrong_cfg = 1; rsp_cfg = 1;
        do_case("wrongtag", 1, 1, 64'h4000, 64'h4010, 64'h3, 64'h4);
        wrong_cfg = 0; rsp_cfg = 0;

        salt = 8'h00;
        do_case("unaligned", 1, 0, 64'h1003, 64'h0, 64'hABCD, 64'h1234);
        check("unaligned.op1_const", got_op1, SPLIT ? 64'h0A09080706050403 : 64'h0);

        do_case("wrap", 0, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h9, 64'hA);

        noresp_cfg = 1;
        run_instr(1, 0, 64'h6000, 64'h0, 64'h77, 64'h88);
        check("tmo.timeout", 64'(timed_out), 64'd0);
        check("tmo.err", 64'(got_err), 64'd1);
        check("tmo.op2", got_op2, 64'h88);
        check("tmo.latency", 64'(got_lat), 64'(2 + TIMEOUT_CYC));
        check("tmo.nreq", 64'(got_q.size()), 64'd1);
        if (timed_out) do_reset();
        noresp_cfg = 0;

        // Reset while waiting for a response, then a stale response must be ignored.
        @(negedge clk);
        inValid = 1'b1; isMemSrc1In = 1'b1; isMemSrc2In = 1'b0; memAddrSrc1In = 64'h5000;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0; memReqReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        memReqReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstwait.reqValid", 64'(memReqValid), 64'd0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstwait.inReady", 64'(inReady), 64'd1);
        check("rstwait.outValid", 64'(outValid), 64'd0);
        reset_n = 1'b1;
        memRespValid = 1'b1; memRespTag = 1'b0; memRespData = 64'h1234;
        @(posedge clk);
        @(negedge clk);
        memRespValid = 1'b0;
        check("rstwait.stale_outValid", 64'(outValid), 64'd0);
        check("rstwait.stale_inReady", 64'(inReady), 64'd1);
        check("rstwait.stale_op1", operand1ValOut, 64'd0);

        for (int t = 0; t < 30; t++) begin
            salt = 8'($urandom);
            rd_cfg = $urandom_range(0, 3); rsp_cfg = $urandom_range(0, 3);
            wrong_cfg = 1'($urandom_range(0, 1)); hold_cfg = $urandom_range(0, 2);
            a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a1[2:0] = 3'd0;
            if ($urandom_range(0, 1) == 0) a2[2:0] = 3'd0;
            do_case($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), a1, a2,
                    {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
